clock_div_by_n: RTL and testbench

// Integer clock divider: derives a ~50% duty-cycle clock at f(clk)/DIV from
// a single input clock. It feeds low-rate logic and scope/debug taps; several

---
 rtl/clock_div_by_n.sv | 74 +++++++
 tb/tb_clock_div_by_n.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clock_div_by_n.sv
// Integer clock divider: registered ~50% duty output at f(clk)/DIV.
// Even DIV uses one posedge register; odd DIV ANDs it with a negedge-delayed copy.
`timescale 1ns/1ps

module clock_div_by_n #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic clk_div
);

    localparam int CW   = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int HALF = DIV / 2;
    localparam int LAST = DIV - 1;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("clock_div_by_n: DIV must be an integer >= 2");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          hi_q;
    logic          hi_d;

    // Decoding the pre-edge count keeps hi_q in phase with the counter.
    // Even DIV: high for counts HALF..DIV-1.
    // Odd DIV: hi_q leads the output rise by half a cycle and is trimmed by lo_q.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAST)) begin
            cnt_d = '0;
        end
        hi_d = (cnt_q >= CW'(HALF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            hi_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
        end
    end

    generate
        if ((DIV % 2) == 0) begin : g_even
            assign clk_div = hi_q;
        end else begin : g_odd
            logic lo_q;
            logic lo_d;

            always_comb begin
                lo_d = hi_q;
            end

            // Half-cycle delayed copy; the AND rises on the falling edge and
            // falls with hi_q on the rising edge, so only one input moves at a time.
            always_ff @(negedge clk) begin
                if (rst) begin
                    lo_q <= 1'b0;
                end else begin
                    lo_q <= lo_d;
                end
            end

            assign clk_div = hi_q & lo_q;
        end
    endgenerate

endmodule

// File: tb/tb_clock_div_by_n.sv
// Bench for clock_div_by_n: six dividers on one clk; expected edge times are
// queued per instance and an edge monitor pops and compares on every output change.
`timescale 1ns/1ps

module tb_clock_div_by_n;

    localparam int NI = 6;

    function automatic int div_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            3:       return 5;
            4:       return 8;
            default: return 16;
        endcase
    endfunction

    typedef struct {
        int   t;
        logic v;
    } edge_t;

    logic          clk;
    logic          rst;
    logic [NI-1:0] div_out;
    logic          mon_en;
    int            checks;
    int            errors;
    edge_t         exp_q[NI][$];

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check_edge(input int i, input logic v);
        edge_t e;
        int    t;
        t = int'($time);
        checks++;
        if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL edge_div%0d: got edge to %0b at %0d ns, required no edge", div_of(i), v, t);
        end else begin
            e = exp_q[i].pop_front();
            if (e.t != t || e.v !== v) begin
                errors++;
                $display("FAIL edge_div%0d: got edge to %0b at %0d ns, required edge to %0b at %0d ns",
                         div_of(i), v, t, e.v, e.t);
            end else begin
                $display("edge div%0d: to %0b at %0d ns ok", div_of(i), v, t);
            end
        end
    endtask

    // Expected waveform from E0 at t0: rises at t0+D+2Dn ns, falls at t0+2D+2Dn ns
    // (clk period 2 ns). A reset edge at t_end forces a high output low.
    task automatic gen_edges(input int t0, input int t_end, input bit rst_at_end);
        for (int i = 0; i < NI; i++) begin
            int   d;
            logic last;
            edge_t e;
            d    = div_of(i);
            last = 1'b0;
            for (int t = t0 + d; t < t_end; t += d) begin
                e.t  = t;
                e.v  = (((t - t0) / d) % 2) == 1;
                last = e.v;
                exp_q[i].push_back(e);
            end
            if (rst_at_end && last) begin
                e.t = t_end;
                e.v = 1'b0;
                exp_q[i].push_back(e);
            end
        end
    endtask

    task automatic check_level(input string name, input logic [NI-1:0] req);
        checks++;
        if (div_out !== req) begin
            errors++;
            $display("FAIL %s: got %b at %0d ns, required %b", name, div_out, int'($time), req);
        end else begin
            $display("level %s: %b at %0d ns ok", name, div_out, int'($time));
        end
    endtask

    task automatic check_drained(input string phase);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL missing_edges_div%0d_%s: got %0d pending, required 0 (next %0b at %0d ns)",
                         div_of(i), phase, exp_q[i].size(), exp_q[i][0].v, exp_q[i][0].t);
                exp_q[i].delete();
            end else begin
                $display("drain div%0d %s: ok", div_of(i), phase);
            end
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        clock_div_by_n #(.DIV(div_of(gi))) u_dut (
            .clk     (clk),
            .rst     (rst),
            .clk_div (div_out[gi])
        );

        always @(div_out[gi]) begin
            if (mon_en) begin
                check_edge(gi, div_out[gi]);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst    = 1'b1;

        // Reset held over posedges 1,3,5,7: outputs must stay low.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_level("reset_low", '0);
        end
        @(posedge clk);
        #0.5;
        // E0 = 9 ns; mid-run reset edge at 37 ns while DIV=8 output is high.
        gen_edges(9, 37, 1'b1);
        mon_en = 1'b1;
        rst    = 1'b0;

        #29;
        rst = 1'b1;
        #1;
        check_level("midrun_reset_low", '0);
        check_drained("phase1");

        // Restart from E0 = 39 ns and run a long stretch of steady state.
        gen_edges(39, 160, 1'b0);
        rst = 1'b0;
        #122.5;
        check_drained("phase2");

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
